// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: DrawX/DrawY counters plus delayed hs/vs/blank.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   // idle value of {hs, vs, blank}
   localparam logic [2:0] SYNC_IDLE = 3'b110;

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       h_last;
   logic       v_last;
   logic       start_nxt;
   logic       start_q;
   logic       hs_raw;
   logic       vs_raw;
   logic       blank_raw;
   logic [2:0] sync_raw;
   logic [2:0] sync_out;

   always_comb begin
      h_last = (h_cnt == H_LAST);
      v_last = (v_cnt == V_LAST);
      h_nxt  = h_cnt + 10'd1;
      v_nxt  = v_cnt;
      if (h_last) begin
         h_nxt = '0;
         v_nxt = v_last ? '0 : v_cnt + 10'd1;
      end
      start_nxt = (h_nxt == '0) && (v_nxt == '0);
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         start_q <= 1'b0;
      end else begin
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
         start_q <= start_nxt;
      end
   end

   always_comb begin
      hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_raw    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
      blank_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      sync_raw  = {hs_raw, vs_raw, blank_raw};
   end

   generate
      if (PIPE_DELAY == 0) begin : g_nodelay
         assign sync_out = sync_raw;
      end else begin : g_delay
         // stage k holds the decode of the counters k+1 clocks ago
         logic [2:0] pipe [PIPE_DELAY];

         always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
               for (int i = 0; i < PIPE_DELAY; i++)
                  pipe[i] <= SYNC_IDLE;
            end else begin
               pipe[0] <= sync_raw;
               for (int i = 1; i < PIPE_DELAY; i++)
                  pipe[i] <= pipe[i-1];
            end
         end

         assign sync_out = pipe[PIPE_DELAY-1];
      end
   endgenerate

   assign DrawX       = h_cnt;
   assign DrawY       = v_cnt;
   assign hs          = sync_out[2];
   assign vs          = sync_out[1];
   assign blank       = sync_out[0];
   assign frame_start = start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge vga_clk) begin
      if (!reset_n)
         frame_cnt <= '0;
      else if (start_nxt)
         frame_cnt <= frame_cnt + 16'd1;
   end

   assign frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: arithmetic raster model plus directed literal checks.
// Uses a full-size instance and two reduced-geometry instances to stay short.
module tb_vga_timing_gen;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   always #20 vga_clk = ~vga_clk;

   int checks   = 0;
   int failures = 0;

   // clocks since the last reset edge; all instances share reset
   int p     = 0;
   bit armed = 1'b0;

   always @(posedge vga_clk) begin
      if (!reset_n) begin
         p     <= 0;
         armed <= 1'b1;
      end else begin
         p <= p + 1;
      end
   end

   logic [9:0] dx_d, dy_d, dx_0, dy_0, dx_7, dy_7;
   logic hs_d, vs_d, bl_d, fs_d;
   logic hs_0, vs_0, bl_0, fs_0;
   logic hs_7, vs_7, bl_7, fs_7;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fc_d, fc_0, fc_7;
`endif

   vga_timing_gen u_def (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(dx_d), .DrawY(dy_d),
      .hs(hs_d), .vs(vs_d), .blank(bl_d),
      .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc_d)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DELAY(0)
   ) u_s0 (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(dx_0), .DrawY(dy_0),
      .hs(hs_0), .vs(vs_0), .blank(bl_0),
      .frame_start(fs_0)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc_0)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DELAY(7)
   ) u_s7 (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(dx_7), .DrawY(dy_7),
      .hs(hs_7), .vs(vs_7), .blank(bl_7),
      .frame_start(fs_7)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(fc_7)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s p=%0d got=%h want=%h", name, p, act, exp);
      end
   endtask

   // expected {DrawX, DrawY, hs, vs, blank, frame_start} after p clocks
   function automatic logic [23:0] model(int pc, int hv, int hf, int hsw,
                                         int hb, int vv, int vf, int vsw,
                                         int vb, int pd);
      int ht, vt, q, xq, yq;
      logic h, v, b, f;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      f  = (pc > 0) && (pc % (ht * vt) == 0);
      q  = pc - pd;
      h  = 1'b1;
      v  = 1'b1;
      b  = 1'b0;
      if (q >= 0) begin
         xq = q % ht;
         yq = (q / ht) % vt;
         h  = !(xq >= hv + hf && xq < hv + hf + hsw);
         v  = !(yq >= vv + vf && yq < vv + vf + vsw);
         b  = (xq < hv) && (yq < vv);
      end
      return {10'(pc % ht), 10'((pc / ht) % vt), h, v, b, f};
   endfunction

`ifdef VGA_FRAME_CNT_EN
   int fc_base = 0;
`endif

   always @(negedge vga_clk) begin
      if (armed) begin
         chk("def", 32'({dx_d, dy_d, hs_d, vs_d, bl_d, fs_d}),
             32'(model(p, 640, 16, 96, 48, 480, 10, 2, 33, 2)));
         chk("s0", 32'({dx_0, dy_0, hs_0, vs_0, bl_0, fs_0}),
             32'(model(p, 8, 2, 3, 2, 4, 1, 2, 1, 0)));
         chk("s7", 32'({dx_7, dy_7, hs_7, vs_7, bl_7, fs_7}),
             32'(model(p, 8, 2, 3, 2, 4, 1, 2, 1, 7)));
`ifdef VGA_FRAME_CNT_EN
         chk("fc_s0", 32'(fc_0), 32'(16'(fc_base + p / 120)));
         chk("fc_s7", 32'(fc_7), 32'(16'(p / 120)));
`endif
      end
   end

   // first-event timestamps used by the literal checks
   int  hs_fall = -1, hs_rise = -1, bl_rise = -1, bl_fall = -1;
   int  vs_fall = -1, vs_rise = -1, fs1 = -1, fs2 = -1;
   logic hs_prev = 1'b1, bl_prev = 1'b0, vs_prev = 1'b1;

   always @(negedge vga_clk) begin
      if (armed && reset_n) begin
         if (hs_prev && !hs_d && hs_fall < 0) hs_fall = p;
         if (!hs_prev && hs_d && hs_rise < 0) hs_rise = p;
         if (!bl_prev && bl_d && bl_rise < 0) bl_rise = p;
         if (bl_prev && !bl_d && bl_fall < 0) bl_fall = p;
         if (vs_prev && !vs_0 && vs_fall < 0) vs_fall = p;
         if (!vs_prev && vs_0 && vs_rise < 0) vs_rise = p;
         if (fs_0 && fs1 >= 0 && fs2 < 0) fs2 = p;
         if (fs_0 && fs1 < 0) fs1 = p;
      end
      hs_prev = hs_d;
      bl_prev = bl_d;
      vs_prev = vs_0;
   end

   task automatic wait_p(input int target);
      int n;
      n = 0;
      while (p != target && n < 5000) begin
         @(negedge vga_clk);
         n++;
      end
      if (p != target) chk("wait_p", 32'(p), 32'(target));
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      chk("t1_x", 32'(dx_d), 32'd0);
      chk("t1_y", 32'(dy_d), 32'd0);
      chk("t1_sync", 32'({hs_d, vs_d, bl_d, fs_d}), 32'b1100);
      chk("t5_blank0", 32'(bl_0), 32'd1);
      repeat (5) @(negedge vga_clk);
      chk("t1_x5", 32'(dx_d), 32'd5);
      wait_p(6);
      chk("s7_idle6", 32'(bl_7), 32'd0);
      @(negedge vga_clk);
      chk("s7_vis7", 32'(bl_7), 32'd1);
      chk("t5_vis7", 32'(bl_0), 32'd1);
      @(negedge vga_clk);
      chk("t5_blank8", 32'({dx_0, bl_0}), 32'({10'd8, 1'b0}));
      wait_p(119);
      chk("t3_end", 32'({dx_0, dy_0, fs_0}), 32'({10'd14, 10'd7, 1'b0}));
      @(negedge vga_clk);
      chk("t3_wrap", 32'({dx_0, dy_0, fs_0}), 32'({10'd0, 10'd0, 1'b1}));
      wait_p(1900);
      chk("t2_hs_fall", 32'(hs_fall), 32'd658);
      chk("t2_hs_low", 32'(hs_rise - hs_fall), 32'd96);
      chk("t2_bl_rise", 32'(bl_rise), 32'd2);
      chk("t2_bl_len", 32'(bl_fall - bl_rise), 32'd640);
      chk("t3_vs_fall", 32'(vs_fall), 32'd75);
      chk("t3_vs_low", 32'(vs_rise - vs_fall), 32'd30);
      chk("t3_fs1", 32'(fs1), 32'd120);
      chk("t3_period", 32'(fs2 - fs1), 32'd120);
      chk("t4_pos", 32'({dx_d, dy_d}), 32'({10'd300, 10'd2}));
      reset_n = 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fc_base = 0;
`endif
      @(negedge vga_clk);
      reset_n = 1'b1;
      chk("t4_zero", 32'({dx_d, dy_d, hs_d, vs_d, bl_d}),
          32'({10'd0, 10'd0, 3'b110}));
      @(negedge vga_clk);
      chk("t4_idle1", 32'({hs_d, bl_d}), 32'b10);
      @(negedge vga_clk);
      chk("t4_vis2", 32'({hs_d, bl_d}), 32'b11);
      wait_p(300);
`ifdef VGA_FRAME_CNT_EN
      chk("t6_fc", 32'(fc_0), 32'd2);
      force u_s0.frame_cnt = 16'hFFFF;
      fc_base = 65535 - p / 120;
      #1;
      release u_s0.frame_cnt;
      begin
         int n;
         n = 0;
         @(negedge vga_clk);
         while (!fs_0 && n < 200) begin
            @(negedge vga_clk);
            n++;
         end
         chk("t6_wrap", 32'({fs_0, fc_0}), 32'({1'b1, 16'd0}));
      end
`endif
      repeat (10) @(negedge vga_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
